// File: rtl/rdy_vld_if.sv
// Ready/valid handshake bundle. The producer side uses src, the consumer side uses dst.
interface rdy_vld_if #(
    parameter type data_st = logic [1:0]
) ();
    logic   vld;
    logic   rdy;
    data_st data;

    // Producer: drives vld/data, samples rdy
    modport src (output vld, output data, input rdy);
    // Consumer: samples vld/data, drives rdy
    modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/rdy_vld_fifo.sv
// First-word-fall-through FIFO with ready/valid on both sides.
// in.rdy depends only on registered state and rst, never on out.rdy. A full FIFO therefore
// does not accept a push in the same cycle as a pop; in.rdy reopens the cycle after.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module rdy_vld_fifo #(
    parameter type         data_st      = logic [1:0],
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    rdy_vld_if.dst           in,
    rdy_vld_if.src           out,
    output logic [CNT_W-1:0] level,
    output logic             almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CntFull  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CntAfull = CNT_W'(AFULL_THRESH);

    data_st             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    // Handshake outputs; rst masks everything so reset looks empty immediately
    always_comb begin
        in.rdy      = (cnt_q != CntFull) && !rst;
        out.vld     = (cnt_q != '0) && !rst;
        out.data    = mem_q[rd_ptr_q];
        level       = rst ? '0 : cnt_q;
        almost_full = !rst && (cnt_q >= CntAfull);
    end

    assign push = in.vld && in.rdy;
    assign pop  = out.vld && out.rdy;

    // Pointer and count next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never cleared; a push can never target the head since in.rdy is low when full
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in.data;
        end
    end

    // Overflow/underflow guards and stall stability
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt_q == CntFull)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && (cnt_q == '0)));
    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        (out.vld && !out.rdy) |=> (out.vld && $stable(out.data)));

endmodule

// File: tb/tb_rdy_vld_fifo.sv
// Directed and random checks for rdy_vld_fifo with DEPTH=4, AFULL_THRESH=3.
module tb_rdy_vld_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [2:0] level;
    logic       almost_full;

    rdy_vld_if #(.data_st(logic [1:0])) in_if ();
    rdy_vld_if #(.data_st(logic [1:0])) out_if ();

    rdy_vld_fifo #(
        .data_st      (logic [1:0]),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_if),
        .out         (out_if),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] data;
        logic       rdy;
        logic       e_in_rdy;
        logic       e_out_vld;
        logic [1:0] e_data;
        int         e_level;
        logic       e_af;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic v, input logic [1:0] d,
                                input logic rd, input logic eir, input logic eov,
                                input logic [1:0] ed, input int el, input logic eaf);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.rdy = rd;
        t.e_in_rdy = eir; t.e_out_vld = eov; t.e_data = ed; t.e_level = el; t.e_af = eaf;
        vecs.push_back(t);
    endfunction

    // Apply inputs in the low phase; outputs are then sampled well before the next rising edge
    task automatic apply(input logic r, input logic v, input logic [1:0] d, input logic rd);
        @(negedge clk);
        rst        = r;
        in_if.vld  = v;
        in_if.data = d;
        out_if.rdy = rd;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic eir, input logic eov,
                              input logic [1:0] ed, input int el, input logic eaf);
        check({tag, ".in_rdy"}, int'(in_if.rdy), int'(eir));
        check({tag, ".out_vld"}, int'(out_if.vld), int'(eov));
        if (eov) check({tag, ".out_data"}, int'(out_if.data), int'(ed));
        check({tag, ".level"}, int'(level), el);
        check({tag, ".afull"}, int'(almost_full), int'(eaf));
    endtask

    logic [1:0] model_q[$];

    initial begin
        rst = 1'b1; in_if.vld = 1'b0; in_if.data = '0; out_if.rdy = 1'b0;

        // Reset, fill to full with stall, one pop from full, then drain
        //   rst v  d     rdy  in_rdy out_vld data  lvl af
        add(1, 0, 2'd0, 0,   0,     0,      2'd0, 0,  0);
        add(1, 0, 2'd0, 0,   0,     0,      2'd0, 0,  0);
        add(0, 1, 2'd0, 0,   1,     0,      2'd0, 0,  0);
        add(0, 1, 2'd1, 0,   1,     1,      2'd0, 1,  0);
        add(0, 1, 2'd2, 0,   1,     1,      2'd0, 2,  0);
        add(0, 1, 2'd3, 0,   1,     1,      2'd0, 3,  1);
        for (int i = 0; i < 10; i++) add(0, 1, 2'd2, 0, 0, 1, 2'd0, 4, 1);
        add(0, 1, 2'd0, 1,   0,     1,      2'd0, 4,  1);  // pop 0, push blocked
        add(0, 1, 2'd0, 0,   1,     1,      2'd1, 3,  1);  // push 0
        add(0, 0, 2'd0, 1,   0,     1,      2'd1, 4,  1);
        add(0, 0, 2'd0, 1,   1,     1,      2'd2, 3,  1);
        add(0, 0, 2'd0, 1,   1,     1,      2'd3, 2,  0);
        add(0, 0, 2'd0, 1,   1,     1,      2'd0, 1,  0);
        add(0, 0, 2'd0, 0,   1,     0,      2'd0, 0,  0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rdy);
            check_outs($sformatf("vec%0d", i), vecs[i].e_in_rdy, vecs[i].e_out_vld,
                       vecs[i].e_data, vecs[i].e_level, vecs[i].e_af);
        end

        // Continuous stream of 20 words from empty: 1-cycle latency then 1 word/cycle
        for (int k = 0; k < 21; k++) begin
            apply(0, k < 20, 2'(k), 1);
            if (k == 0) check_outs("stream0", 1, 0, 2'd0, 0, 0);
            else check_outs($sformatf("stream%0d", k), 1, 1, 2'(k - 1), 1, 0);
        end
        apply(0, 0, 2'd0, 0);
        check_outs("stream_end", 1, 0, 2'd0, 0, 0);

        // Random traffic against a reference queue
        for (int c = 0; c < 1000; c++) begin
            logic v, rd;
            logic [1:0] d;
            logic e_ir, e_ov;
            v  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            d  = 2'($urandom_range(0, 3));
            apply(0, v, d, rd);
            e_ir = (model_q.size() != DEPTH);
            e_ov = (model_q.size() != 0);
            check_outs($sformatf("rand%0d", c), e_ir, e_ov,
                       e_ov ? model_q[0] : 2'd0, model_q.size(), model_q.size() >= 3);
            if (e_ov && rd) void'(model_q.pop_front());
            if (v && e_ir) model_q.push_back(d);
        end

        // Drain, then reset mid-stream at level 3
        for (int k = 0; k < 5; k++) apply(0, 0, 2'd0, 1);
        apply(0, 1, 2'd1, 0);
        check_outs("pre_rst_empty", 1, 0, 2'd0, 0, 0);
        apply(0, 1, 2'd3, 0);
        apply(0, 1, 2'd0, 0);
        apply(0, 0, 2'd0, 0);
        check_outs("pre_rst_l3", 1, 1, 2'd1, 3, 1);
        apply(1, 0, 2'd0, 0);
        check_outs("in_rst", 0, 0, 2'd0, 0, 0);
        apply(0, 1, 2'd2, 0);
        check_outs("post_rst", 1, 0, 2'd0, 0, 0);
        apply(0, 0, 2'd0, 1);
        check_outs("post_rst_first", 1, 1, 2'd2, 1, 0);
        apply(0, 0, 2'd0, 0);
        check_outs("post_rst_empty", 1, 0, 2'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rdy_vld_fifo.md
Name: rdy_vld_fifo

Overview:
- Synchronous first-word-fall-through FIFO with a ready/valid handshake on both sides.
- Sits between a producer's rdy_vld_if (src modport) and a consumer's rdy_vld_if (dst modport).
- Decouples backpressure and absorbs bursts.
- No combinational path from out.rdy to in.rdy, so it also acts as a timing break in handshake chains.

Parameters:
- data_st, logic[1:0], payload type carried through; matches the interface's data_st.
- DEPTH, 4, number of entries; power of two, ≥2.
- AFULL_THRESH, DEPTH-1, level at or above which almost_full asserts; range 1..DEPTH.
- Derived: CNT_W = $clog2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  rdy_vld_if.dst  data_st  upstream side; block drives in.rdy and samples in.vld and in.data.
- out  rdy_vld_if.src  data_st  downstream side; block drives out.vld and out.data and samples out.rdy.
- level  output  CNT_W  current entry count, 0..DEPTH.
- almost_full  output  1  level ≥ AFULL_THRESH.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Transfer rules:
  - push = in.vld && in.rdy.
  - pop = out.vld && out.rdy.
  - A transfer occurs only in a cycle where both handshake signals are high at the clock edge.
- Storage: DEPTH-entry array, write pointer wr_ptr, read pointer rd_ptr, count cnt. All are registered.
- Pointers: each is log2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Count update: cnt next = cnt + push − pop.
- in.rdy = (cnt != DEPTH) && !rst.
  - Depends only on registered state and rst; never on out.rdy.
  - When full, a simultaneous pop does NOT enable a push in that same cycle. in.rdy rises the cycle after the pop.
- out.vld = (cnt != 0). out.data = mem[rd_ptr] (FWFT).
- Latency: a word pushed at edge N is presented with out.vld=1 in the cycle after edge N. Minimum in-to-out latency is 1 cycle; there is no bypass when empty.
- Throughput: 1 word per cycle sustained when 0 < cnt < DEPTH with both sides active.
- Empty plus push: cnt 0→1; out.vld goes high the next cycle.
- Simultaneous push and pop with 0 < cnt < DEPTH: cnt is unchanged and both pointers advance.
- Stability while stalled:
  - While out.vld && !out.rdy, out.data and out.vld stay stable.
  - Pushes never overwrite the head entry.
- Upstream obligations:
  - The block accepts in.vld dropping without a transfer.
  - in.data is sampled only on push.
- Reset, including mid-operation:
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - Outputs during and after reset: out.vld=0, level=0, almost_full=0 (for AFULL_THRESH ≥ 1). in.rdy=0 while rst is high and 1 in the first cycle after rst drops.
  - Stored contents are discarded. Memory is not cleared, and out.data is don't-care while out.vld=0.
- Error guards:
  - Overflow and underflow cannot occur by construction.
  - Assertions: never push when cnt==DEPTH; never pop when cnt==0; out.data is stable under stall.
- Implementation budget: roughly 150–250 lines, including assertions.

Test Plan:
- Reset then idle → in.rdy=0 during rst; in.rdy=1 and out.vld=0, level=0 the cycle after.
- Push 0,1,2,3 on consecutive cycles with out.rdy=0 (DEPTH=4) → level 1,2,3,4.
  - almost_full asserts at level 3; in.rdy=0 at level 4.
  - out.data=0 is held stable for 10 stalled cycles.
- From full, raise out.rdy for 1 cycle while in.vld=1 → pops 0 and does not push that cycle; in.rdy=1 next cycle; then push 2'd0 → output order 1,2,3,0.
- Continuous stream of 20 words with in.vld=1 and out.rdy=1 from empty → first out.vld 1 cycle after first push; then 1 word/cycle, level steady at 1, all data in order.
- Random in.vld / out.rdy (50% each) for 1000 cycles, checked against a reference queue → no loss, duplication, or reordering; assertions silent.
- Assert rst with level=3 mid-stream → next cycle level=0, out.vld=0; the first word pushed after reset is the first word output.
